// File: rtl/writeback_stage.sv
// MEM/WB pipeline register and write side of the register file and NZCV status register.
// Also keeps a retired-instruction counter and a sticky flag for blocked PC writebacks.
module writeback_stage #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned REG_ADDR_W = 4,
  parameter int unsigned PC_REG     = 15,
  parameter int unsigned CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  freeze,
  input  logic                  flush,
  input  logic                  valid_in,
  input  logic                  wb_en_in,
  input  logic                  mem_read_in,
  input  logic [DATA_W-1:0]     alu_result_in,
  input  logic [DATA_W-1:0]     mem_data_in,
  input  logic [REG_ADDR_W-1:0] dest_in,
  input  logic                  status_we_in,
  input  logic [3:0]            status_in,
  output logic                  wb_en_out,
  output logic [REG_ADDR_W-1:0] wb_dest_out,
  output logic [DATA_W-1:0]     wb_value_out,
  output logic [3:0]            status_reg_out,
  output logic [CNT_W-1:0]      retired_count,
  output logic                  pc_write_err
);

  localparam logic [REG_ADDR_W-1:0] PC_ADDR = REG_ADDR_W'(PC_REG);

  logic                  r_valid;
  logic                  r_wb_en;
  logic                  r_mem_read;
  logic [REG_ADDR_W-1:0] r_dest;
  logic [DATA_W-1:0]     r_alu;
  logic [DATA_W-1:0]     r_mem;
  logic [3:0]            r_status;
  logic [CNT_W-1:0]      r_retired_count;
  logic                  r_pc_err;

  logic                  w_load;
  logic                  w_pc_hit_in;

  assign w_load      = !freeze && !flush;
  // Enables are qualified with valid_in so X on a bubble's fields never reaches wb_en_out.
  assign w_pc_hit_in = valid_in && wb_en_in && (dest_in == PC_ADDR);

  // MEM/WB pipeline register: freeze holds, flush loads a bubble.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid    <= 1'b0;
      r_wb_en    <= 1'b0;
      r_mem_read <= 1'b0;
      r_dest     <= '0;
      r_alu      <= '0;
      r_mem      <= '0;
    end else if (!freeze) begin
      if (flush) begin
        r_valid    <= 1'b0;
        r_wb_en    <= 1'b0;
        r_mem_read <= 1'b0;
        r_dest     <= '0;
        r_alu      <= '0;
        r_mem      <= '0;
      end else begin
        r_valid    <= valid_in;
        r_wb_en    <= valid_in & wb_en_in;
        r_mem_read <= valid_in & mem_read_in;
        r_dest     <= dest_in;
        r_alu      <= alu_result_in;
        r_mem      <= mem_data_in;
      end
    end
  end

  // Architectural NZCV; flush deliberately does not block an EXE flag update.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_status <= 4'b0000;
    end else if (!freeze && status_we_in) begin
      r_status <= status_in;
    end
  end

  // Retired counter and sticky PC-write error, both updated as the entry is loaded.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_retired_count <= '0;
      r_pc_err        <= 1'b0;
    end else if (w_load) begin
      if (valid_in) begin
        r_retired_count <= r_retired_count + CNT_W'(1);
      end
      if (w_pc_hit_in) begin
        r_pc_err <= 1'b1;
      end
    end
  end

  assign wb_en_out      = r_valid & r_wb_en & (r_dest != PC_ADDR);
  assign wb_dest_out    = r_dest;
  assign wb_value_out   = r_mem_read ? r_mem : r_alu;
  assign status_reg_out = r_status;
  assign retired_count  = r_retired_count;
  assign pc_write_err   = r_pc_err;

endmodule
